clk_period_chk: RTL and testbench
=================================

CLK_PERIOD_CHK -- requirements
Module: clk_period_chk

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period counter and limits.
REQ-002 SHALL have parameter LOCK_CNT, default 8, consecutive in-range periods required to lock.
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  sampling/reference clock (first).
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port mon_clk  in  1  monitored clock, pre-synchronised to clk, treated as data.
REQ-007 SHALL have port chk_en  in  1  enable; low forces IDLE.
REQ-008 SHALL have port cfg_min_per  in  CNT_W  minimum legal period, in clk cycles.
REQ-009 SHALL have port cfg_max_per  in  CNT_W  maximum legal period, in clk cycles.
REQ-010 SHALL have port alarm_clr  in  1  single-cycle alarm clear.
REQ-011 SHALL have port period  out  CNT_W  last reported period, in clk cycles.
REQ-012 SHALL have port period_vld  out  1  one-cycle strobe when period updates.
REQ-013 SHALL have port locked  out  1  high in LOCKED.
REQ-014 SHALL have port alarm  out  1  sticky, high in ALARM.
REQ-015 SHALL have port err_cnt  out  8  saturating out-of-range event count.

Function
REQ-016 SHALL register mon_clk; rising edge = mon_clk & ~mon_clk_q.
REQ-017 SHALL count with cnt: cnt<=1 on an edge cycle, else cnt+1, saturating at all-ones; measurement at edge = cnt (cycles between successive edges).
REQ-018 SHALL discard the first edge after reset or after chk_en rises (no previous reference edge).
REQ-019 SHALL drive period/period_vld one cycle after the edge cycle (latency 1); period holds between strobes.
REQ-020 SHALL class a measurement as in range when cfg_min_per <= m <= cfg_max_per (inclusive); cfg_min_per > cfg_max_per makes every measurement out of range.
REQ-021 SHALL flag a timeout, treated as one out-of-range event, when cnt reaches cfg_max_per+1 with no edge; cnt then saturates and does not re-flag until the next edge.
REQ-022 SHALL implement FSM IDLE, ACQ, LOCKED, ALARM.
REQ-023 SHALL transition IDLE->ACQ when chk_en=1; any state->IDLE when chk_en=0, clearing the good counter, err_cnt, alarm and locked.
REQ-024 SHALL in ACQ increment the good counter per in-range measurement, zero it on out-of-range/timeout, and go to LOCKED when it reaches LOCK_CNT.
REQ-025 SHALL transition LOCKED->ALARM on any out-of-range measurement or timeout.
REQ-026 SHALL hold ALARM until alarm_clr, then go to ACQ with the good counter 0; a measurement in the same cycle as alarm_clr is ignored for state.
REQ-027 SHALL increment err_cnt on every out-of-range or timeout event in ACQ/LOCKED/ALARM, saturating at 255.
REQ-028 SHALL let chk_en=0 win over alarm_clr and measurement when simultaneous.

Reset
REQ-029 SHALL on rst clear state to IDLE and set period=0, period_vld=0, locked=0, alarm=0, err_cnt=0, cnt=0, mon_clk_q=0, first-edge flag set, averaging history empty.
REQ-030 SHALL let rst mid-measurement abandon it with no strobe.

Configuration
REQ-031 SHALL use macro CLK_PERIOD_CHK_AVG_EN: when defined, period and the range check use the mean of the last 4 measurements (sum>>2, sum width CNT_W+2); period_vld first asserts at the 4th valid measurement after IDLE exit, and the history is flushed on IDLE; when undefined, the raw measurement is used with no history registers.

Structure
REQ-032 SHALL keep the FSM state enum and LOCK_CNT/CNT_W defaults in shared package clkmon_pkg.
REQ-033 SHALL place edge detect, counter and timeout in sub-module clk_period_meas; the parent holds the FSM, averaging and counters.

Verification
REQ-034 SHALL cover: mon_clk period 10, min 8, max 12, chk_en=1 -> first strobe period=10 (no-avg); locked=1 one cycle after the 8th valid strobe.
REQ-035 SHALL cover: locked, then period changes to 20 -> timeout at cnt=13 -> alarm=1, locked=0, err_cnt=1.
REQ-036 SHALL cover: mon_clk stuck low in ACQ -> one err_cnt increment per timeout, no lock; pulse alarm_clr while in ALARM -> ACQ.
REQ-037 SHALL cover: periods 10,10,10,13 (max 12) -> good counter resets, lock delayed by 4 periods; min=12, max=8 -> never locks.
REQ-038 SHALL cover: rst and chk_en=0 mid-lock -> all outputs per REQ-029 next cycle; first edge after re-enable produces no strobe.
REQ-039 SHALL cover, with CLK_PERIOD_CHK_AVG_EN: periods 8,12,10,10 -> first strobe period=10 at 4th measurement.

Source files
------------

// File: rtl/clkmon_pkg.sv
// Shared types and defaults for the clock period checker.
package clkmon_pkg;

    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned LOCK_CNT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ALARM  = 2'd3
    } chk_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/clk_period_meas.sv
// Edge detector, period counter and timeout detector for the monitored clock.
// The first edge after reset or clear only establishes the reference.
module clk_period_meas
    import clkmon_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             mon_clk,
    input  logic [CNT_W-1:0] cfg_max_per,
    output logic             meas_vld,
    output logic [CNT_W-1:0] meas_val,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             mon_clk_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             first_q;
    logic             first_d;
    logic             armed_q;
    logic             armed_d;
    logic             edge_s;
    logic             at_lim_s;

    assign edge_s   = mon_clk & ~mon_clk_q;
    // Compared one bit wider so a max of all-ones can never time out.
    assign at_lim_s = ({1'b0, cnt_q} == ({1'b0, cfg_max_per} + {{CNT_W{1'b0}}, 1'b1}));
    assign meas_val = cnt_q;

    // Next-state of counter, reference flag and timeout arming.
    always_comb begin
        cnt_d    = cnt_q;
        first_d  = first_q;
        armed_d  = armed_q;
        meas_vld = 1'b0;
        timeout  = 1'b0;
        if (clr) begin
            cnt_d   = {CNT_W{1'b0}};
            first_d = 1'b1;
            armed_d = 1'b1;
        end else if (edge_s) begin
            cnt_d    = CNT_ONE;
            first_d  = 1'b0;
            armed_d  = 1'b1;
            meas_vld = ~first_q;
        end else begin
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
            if (armed_q && at_lim_s) begin
                timeout = 1'b1;
                armed_d = 1'b0;
            end else begin
                armed_d = armed_q;
            end
        end
    end

    // Measurement state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mon_clk_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            first_q   <= 1'b1;
            armed_q   <= 1'b1;
        end else begin
            mon_clk_q <= mon_clk;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            armed_q   <= armed_d;
        end
    end

endmodule

// File: rtl/clk_period_chk.sv
// Clock period checker: reports measured periods and tracks lock/alarm status.
// Define CLK_PERIOD_CHK_AVG_EN to report and range-check the mean of the last 4 periods.
module clk_period_chk
    import clkmon_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             chk_en,
    input  logic [CNT_W-1:0] cfg_min_per,
    input  logic [CNT_W-1:0] cfg_max_per,
    input  logic             alarm_clr,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             alarm,
    output logic [7:0]       err_cnt
);

    localparam int unsigned       GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_CNT - 1);

    logic             meas_vld_s;
    logic [CNT_W-1:0] meas_val_s;
    logic             tmo_s;
    logic             rep_vld_s;
    logic [CNT_W-1:0] rep_val_s;
    logic             in_range_s;
    logic             bad_s;
    logic             ok_s;

    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  period_d;
    logic              vld_q;
    logic              vld_d;
    logic              tmo_q;
    logic              tmo_d;
    chk_state_e        state_q;
    chk_state_e        state_d;
    logic [GOOD_W-1:0] good_q;
    logic [GOOD_W-1:0] good_d;
    logic [7:0]        err_q;
    logic [7:0]        err_d;
    logic              locked_q;
    logic              alarm_q;

    clk_period_meas #(
        .CNT_W (CNT_W)
    ) u_meas (
        .clk         (clk),
        .rst         (rst),
        .clr         (~chk_en),
        .mon_clk     (mon_clk),
        .cfg_max_per (cfg_max_per),
        .meas_vld    (meas_vld_s),
        .meas_val    (meas_val_s),
        .timeout     (tmo_s)
    );

`ifdef CLK_PERIOD_CHK_AVG_EN
    logic [CNT_W-1:0] h0_q;
    logic [CNT_W-1:0] h1_q;
    logic [CNT_W-1:0] h2_q;
    logic [1:0]       hcnt_q;
    logic [CNT_W+1:0] sum_s;

    assign sum_s     = {2'b00, meas_val_s} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
    assign rep_vld_s = meas_vld_s && (hcnt_q == 2'd3);
    assign rep_val_s = CNT_W'(sum_s >> 2);

    // History of the three previous measurements, flushed whenever disabled.
    always_ff @(posedge clk) begin
        if (rst || !chk_en) begin
            h0_q   <= {CNT_W{1'b0}};
            h1_q   <= {CNT_W{1'b0}};
            h2_q   <= {CNT_W{1'b0}};
            hcnt_q <= 2'd0;
        end else if (meas_vld_s) begin
            h0_q   <= meas_val_s;
            h1_q   <= h0_q;
            h2_q   <= h1_q;
            hcnt_q <= (hcnt_q == 2'd3) ? hcnt_q : (hcnt_q + 2'd1);
        end else begin
            hcnt_q <= hcnt_q;
        end
    end
`else
    assign rep_vld_s = meas_vld_s;
    assign rep_val_s = meas_val_s;
`endif

    // The FSM judges the registered strobe, so status trails the strobe by one cycle.
    assign in_range_s = (period_q >= cfg_min_per) && (period_q <= cfg_max_per);
    assign ok_s       = vld_q && in_range_s;
    assign bad_s      = (vld_q && !in_range_s) || tmo_q;

    // Report stage: latch a new period/timeout one cycle after the edge.
    always_comb begin
        period_d = period_q;
        vld_d    = 1'b0;
        tmo_d    = 1'b0;
        if (!chk_en) begin
            period_d = {CNT_W{1'b0}};
        end else begin
            vld_d = rep_vld_s;
            tmo_d = tmo_s;
            if (rep_vld_s) begin
                period_d = rep_val_s;
            end else begin
                period_d = period_q;
            end
        end
    end

    // Lock/alarm state machine and error counting.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        if (!chk_en) begin
            state_d = ST_IDLE;
            good_d  = {GOOD_W{1'b0}};
            err_d   = 8'd0;
        end else begin
            if ((state_q != ST_IDLE) && bad_s) begin
                err_d = sat_inc8(err_q);
            end else begin
                err_d = err_q;
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    if (bad_s) begin
                        good_d = {GOOD_W{1'b0}};
                    end else if (ok_s) begin
                        if (good_q == LOCK_LAST) begin
                            state_d = ST_LOCKED;
                            good_d  = {GOOD_W{1'b0}};
                        end else begin
                            good_d = good_q + {{(GOOD_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        good_d = good_q;
                    end
                end
                ST_LOCKED: begin
                    if (bad_s) begin
                        state_d = ST_ALARM;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_ALARM: begin
                    if (alarm_clr) begin
                        state_d = ST_ACQ;
                        good_d  = {GOOD_W{1'b0}};
                    end else begin
                        state_d = ST_ALARM;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = {GOOD_W{1'b0}};
                end
            endcase
        end
    end

    // Output and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= {CNT_W{1'b0}};
            vld_q    <= 1'b0;
            tmo_q    <= 1'b0;
            state_q  <= ST_IDLE;
            good_q   <= {GOOD_W{1'b0}};
            err_q    <= 8'd0;
            locked_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            period_q <= period_d;
            vld_q    <= vld_d;
            tmo_q    <= tmo_d;
            state_q  <= state_d;
            good_q   <= good_d;
            err_q    <= err_d;
            locked_q <= (state_d == ST_LOCKED);
            alarm_q  <= (state_d == ST_ALARM);
        end
    end

    assign period     = period_q;
    assign period_vld = vld_q;
    assign locked     = locked_q;
    assign alarm      = alarm_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_clk_period_chk.sv
// Directed bench for clk_period_chk with a cycle-level reference model.
module tb_clk_period_chk;

    localparam int CW   = 16;
    localparam int LOCK = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mon_clk;
    logic          chk_en;
    logic [CW-1:0] cfg_min_per;
    logic [CW-1:0] cfg_max_per;
    logic          alarm_clr;
    logic [CW-1:0] period;
    logic          period_vld;
    logic          locked;
    logic          alarm;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    clk_period_chk #(.CNT_W(CW), .LOCK_CNT(LOCK)) dut (
        .clk         (clk),
        .rst         (rst),
        .mon_clk     (mon_clk),
        .chk_en      (chk_en),
        .cfg_min_per (cfg_min_per),
        .cfg_max_per (cfg_max_per),
        .alarm_clr   (alarm_clr),
        .period      (period),
        .period_vld  (period_vld),
        .locked      (locked),
        .alarm       (alarm),
        .err_cnt     (err_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: elapsed cycles since the last reference point, plus a
    // behavioural status machine (0 idle, 1 acquiring, 2 locked, 3 alarm).
    int  m_cyc   = 0;
    int  m_ref   = 0;
    int  m_state = 0;
    int  m_good  = 0;
    int  m_err   = 0;
    int  m_per   = 0;
    bit  m_first = 1'b1;
    bit  m_armed = 1'b1;
    bit  m_prev  = 1'b0;
    bit  m_vld   = 1'b0;
    bit  m_tmo   = 1'b0;
    bit  m_live  = 1'b0;
    int  m_hist[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit clr;
        bit edge_m;
        bit ok_m;
        bit bad_m;
        bit nvld;
        bit ntmo;
        int nper;
        int el;
        clr = rst || !chk_en;
        if (clr) begin
            m_state = 0;
            m_good  = 0;
            m_err   = 0;
        end else begin
            ok_m  = m_vld && (m_per >= int'(cfg_min_per)) && (m_per <= int'(cfg_max_per));
            bad_m = (m_vld && !ok_m) || m_tmo;
            if (m_state != 0 && bad_m && m_err < 255) m_err++;
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (bad_m) m_good = 0;
                    else if (ok_m) begin
                        m_good++;
                        if (m_good == LOCK) begin
                            m_state = 2;
                            m_good  = 0;
                        end
                    end
                end
                2: if (bad_m) m_state = 3;
                3: if (alarm_clr) begin
                    m_state = 1;
                    m_good  = 0;
                end
                default: m_state = 0;
            endcase
        end
        edge_m = mon_clk && !m_prev;
        nper = m_per;
        nvld = 1'b0;
        ntmo = 1'b0;
        if (clr) begin
            m_ref   = m_cyc + 1;
            m_first = 1'b1;
            m_armed = 1'b1;
            m_hist.delete();
            nper    = 0;
        end else begin
            el = m_cyc - m_ref;
            if (el > 65535) el = 65535;
            if (edge_m) begin
                if (m_first) m_first = 1'b0;
                else begin
`ifdef CLK_PERIOD_CHK_AVG_EN
                    m_hist.push_back(el);
                    if (m_hist.size() > 4) m_hist.delete(0);
                    if (m_hist.size() == 4) begin
                        nvld = 1'b1;
                        nper = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
                    end
`else
                    nvld = 1'b1;
                    nper = el;
`endif
                end
                m_ref   = m_cyc;
                m_armed = 1'b1;
            end else if (m_armed && el == int'(cfg_max_per) + 1) begin
                ntmo    = 1'b1;
                m_armed = 1'b0;
            end
        end
        m_prev = rst ? 1'b0 : mon_clk;
        m_per  = nper;
        m_vld  = nvld;
        m_tmo  = ntmo;
        m_cyc++;
        m_live = 1'b1;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (m_live) begin
            cmp("period",     period,     m_per);
            cmp("period_vld", period_vld, m_vld);
            cmp("locked",     locked,     m_state == 2);
            cmp("alarm",      alarm,      m_state == 3);
            cmp("err_cnt",    err_cnt,    m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mon_clk = 1'b0;
            tick();
        end
    endtask

    task automatic pulses(input int per, input int n);
        for (int p = 0; p < n; p++) begin
            mon_clk = 1'b1;
            tick();
            for (int i = 1; i < per; i++) begin
                mon_clk = 1'b0;
                tick();
            end
        end
    endtask

    task automatic restart();
        chk_en = 1'b0;
        idle(1);
        chk_en = 1'b1;
    endtask

    task automatic expect_cleared(input string tag);
        cmp({tag, "_period"}, period, 0);
        cmp({tag, "_vld"},    period_vld, 0);
        cmp({tag, "_locked"}, locked, 0);
        cmp({tag, "_alarm"},  alarm, 0);
        cmp({tag, "_err"},    err_cnt, 0);
    endtask

    initial begin
        rst         = 1'b1;
        chk_en      = 1'b0;
        mon_clk     = 1'b0;
        alarm_clr   = 1'b0;
        cfg_min_per = 16'd8;
        cfg_max_per = 16'd12;
        idle(3);
        expect_cleared("reset");
        rst    = 1'b0;
        chk_en = 1'b1;
`ifndef CLK_PERIOD_CHK_AVG_EN
        // First edge is only a reference; the second yields period 10.
        pulses(10, 1);
        mon_clk = 1'b1;
        tick();
        cmp("first_vld", period_vld, 1);
        cmp("first_period", period, 10);
        idle(9);
        pulses(10, 6);
        mon_clk = 1'b1;
        tick();
        cmp("eighth_vld", period_vld, 1);
        cmp("eighth_not_locked", locked, 0);
        idle(1);
        cmp("lock_after_eighth", locked, 1);
        idle(8);

        // Period stretches to 20: timeout when the count reaches 13.
        mon_clk = 1'b1;
        tick();
        idle(13);
        cmp("pre_tmo_locked", locked, 1);
        cmp("pre_tmo_alarm", alarm, 0);
        idle(1);
        cmp("tmo_alarm", alarm, 1);
        cmp("tmo_locked", locked, 0);
        cmp("tmo_err", err_cnt, 1);
        idle(5);
        mon_clk = 1'b1;
        tick();
        idle(3);
        cmp("alarm_err2", err_cnt, 2);
        alarm_clr = 1'b1;
        idle(1);
        alarm_clr = 1'b0;
        cmp("clr_alarm", alarm, 0);
        // Stuck low in ACQ: a single timeout, no lock.
        idle(40);
        cmp("stuck_err", err_cnt, 3);
        cmp("stuck_locked", locked, 0);
        pulses(10, 10);

        // A 13-cycle period breaks the run and delays lock by four periods.
        restart();
        pulses(10, 3);
        pulses(13, 1);
        pulses(10, 5);
        cmp("delayed_not_locked", locked, 0);
        cmp("delayed_err", err_cnt, 1);
        pulses(10, 4);
        cmp("delayed_locked", locked, 1);

        // Inverted limits: every measurement and timeout is an error.
        cfg_min_per = 16'd12;
        cfg_max_per = 16'd8;
        restart();
        pulses(10, 15);
        idle(2);
        cmp("inv_err", err_cnt, 29);
        cmp("inv_locked", locked, 0);
        cfg_min_per = 16'd8;
        cfg_max_per = 16'd12;

        // Reset mid-lock, then chk_en low mid-lock.
        restart();
        pulses(10, 10);
        mon_clk = 1'b1;
        tick();
        rst     = 1'b1;
        mon_clk = 1'b0;
        tick();
        expect_cleared("rst_mid");
        rst = 1'b0;
        idle(3);
        mon_clk = 1'b1;
        tick();
        cmp("rst_first_edge_vld", period_vld, 0);
        idle(9);
        mon_clk = 1'b1;
        tick();
        cmp("rst_second_vld", period_vld, 1);
        cmp("rst_second_period", period, 10);
        idle(9);
        pulses(10, 10);
        mon_clk = 1'b1;
        tick();
        chk_en  = 1'b0;
        mon_clk = 1'b0;
        tick();
        expect_cleared("dis_mid");
        chk_en = 1'b1;
        idle(2);
        mon_clk = 1'b1;
        tick();
        cmp("en_first_edge_vld", period_vld, 0);
        idle(9);
        mon_clk = 1'b1;
        tick();
        cmp("en_second_vld", period_vld, 1);
        cmp("en_second_period", period, 10);
        idle(9);
`else
        // Periods 8,12,10,10: first strobe is their mean at the 4th measurement.
        restart();
        pulses(8, 1);
        pulses(12, 1);
        pulses(10, 2);
        mon_clk = 1'b1;
        tick();
        cmp("avg_vld", period_vld, 1);
        cmp("avg_period", period, 10);
        idle(9);
        pulses(10, 12);
        cmp("avg_locked", locked, 1);
`endif
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
